// File: rtl/pager_ctl.sv
// Z80 port-write decoder and Pentagon-1024 / ATM pager configuration state,
// shared by the four pager windows; also merges DOS strobes and stall requests.
module pager_ctl (
    input  logic        fclk,
    input  logic        rst_n,
    input  logic        zpos,
    input  logic        zneg,
    input  logic [15:0] za,
    input  logic [7:0]  zd,
    input  logic        iorq_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic [3:0]  dos_turn_on,
    input  logic [3:0]  dos_turn_off,
    input  logic [3:0]  stall_req,
    output logic        atmF7_wr,
    output logic        pent1m_ROM,
    output logic [5:0]  pent1m_page,
    output logic        pent1m_ram0_0,
    output logic        pent1m_1m_on,
    output logic        pager_off,
    output logic        dos,
    output logic        zclk_stall
);

    logic iowr;
    logic iowr_r;
    logic port_stb;
    logic lock;
    logic dec_7ffd;
    logic dec_eff7;
    logic dec_77;
    logic dec_atm;
    logic unused_bits;

    assign unused_bits = ^{zneg, za[14], za[11]};

    always_comb begin
        iowr     = !iorq_n && !wr_n && m1_n;
        port_stb = zpos && iowr && !iowr_r;
        dec_7ffd = !za[15] && !za[1];
        dec_eff7 = (za == 16'hEFF7);
        dec_77   = (za[7:0] == 8'h77);
        dec_atm  = (za[7:0] == 8'hF7) && (za[13:12] == 2'b11) && (za[10:8] == 3'b111);
        atmF7_wr = port_stb && dec_atm;
        zclk_stall = |stall_req;
    end

    // iowr_r resets high so a write already in progress at reset release
    // cannot produce a strobe until iowr has been seen low on a zpos.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            iowr_r <= 1'b1;
        end else if (zpos) begin
            iowr_r <= iowr;
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            pent1m_ROM    <= 1'b0;
            pent1m_page   <= '0;
            pent1m_ram0_0 <= 1'b0;
            pent1m_1m_on  <= 1'b0;
            lock          <= 1'b0;
            pager_off     <= 1'b1;
        end else if (port_stb) begin
            if (dec_7ffd && !lock) begin
                pent1m_page[2:0] <= zd[2:0];
                pent1m_ROM       <= zd[4];
                pent1m_page[4:3] <= zd[7:6];
                // Without 1 MB mode, bit 5 is the 128K lock instead of a page bit.
                if (pent1m_1m_on) begin
                    pent1m_page[5] <= zd[5];
                end else begin
                    pent1m_page[5] <= 1'b0;
                    lock           <= zd[5];
                end
            end
            if (dec_eff7) begin
                pent1m_1m_on  <= ~zd[2];
                pent1m_ram0_0 <= zd[3];
                if (!zd[2]) begin
                    lock <= 1'b0;
                end else begin
                    pent1m_page[5] <= 1'b0;
                end
            end
            if (dec_77) begin
                pager_off <= ~za[9];
            end
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            dos <= 1'b0;
        end else if (|dos_turn_on) begin
            dos <= 1'b1;
        end else if (|dos_turn_off) begin
            dos <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pager_ctl.sv
// Randomized bench for pager_ctl: a bus-level reference model feeds expected
// state and ATM strobe queues that an independent monitor drains and checks.
module tb_pager_ctl;

    logic        fclk;
    logic        rst_n;
    logic        zpos;
    logic        zneg;
    logic [15:0] za;
    logic [7:0]  zd;
    logic        iorq_n;
    logic        wr_n;
    logic        m1_n;
    logic [3:0]  dos_turn_on;
    logic [3:0]  dos_turn_off;
    logic [3:0]  stall_req;
    logic        atmF7_wr;
    logic        pent1m_ROM;
    logic [5:0]  pent1m_page;
    logic        pent1m_ram0_0;
    logic        pent1m_1m_on;
    logic        pager_off;
    logic        dos;
    logic        zclk_stall;

    pager_ctl dut (
        .fclk          (fclk),
        .rst_n         (rst_n),
        .zpos          (zpos),
        .zneg          (zneg),
        .za            (za),
        .zd            (zd),
        .iorq_n        (iorq_n),
        .wr_n          (wr_n),
        .m1_n          (m1_n),
        .dos_turn_on   (dos_turn_on),
        .dos_turn_off  (dos_turn_off),
        .stall_req     (stall_req),
        .atmF7_wr      (atmF7_wr),
        .pent1m_ROM    (pent1m_ROM),
        .pent1m_page   (pent1m_page),
        .pent1m_ram0_0 (pent1m_ram0_0),
        .pent1m_1m_on  (pent1m_1m_on),
        .pager_off     (pager_off),
        .dos           (dos),
        .zclk_stall    (zclk_stall)
    );

    typedef struct {
        logic [5:0] page;
        logic       rom;
        logic       ram0;
        logic       on1m;
        logic       poff;
        logic       dos;
    } st_t;

    st_t          exp_q[$];
    logic [15:0]  atm_q[$];
    int           total = 0;
    int           bad   = 0;

    // Reference model: Pentagon-1024 memory config viewed as named fields.
    logic [5:0] m_page;
    logic       m_rom, m_ram0, m_on1m, m_lock, m_poff, m_dos;

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    // Z80 clock is 4 fclk; zpos/zneg are one-fclk strobes.
    initial begin
        int ph;
        ph = 0;
        zpos = 1'b0;
        zneg = 1'b0;
        forever begin
            @(posedge fclk);
            #1;
            zpos = (ph == 3);
            zneg = (ph == 1);
            ph = (ph + 1) % 4;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    function automatic logic is_atm(input logic [15:0] a);
        return (a[7:0] == 8'hF7) && (a[13:12] == 2'b11) && (a[10:8] == 3'b111);
    endfunction

    task automatic model_reset();
        m_page = 6'd0; m_rom = 1'b0; m_ram0 = 1'b0; m_on1m = 1'b0;
        m_lock = 1'b0; m_poff = 1'b1; m_dos = 1'b0;
    endtask

    task automatic model_out(input logic [15:0] a, input logic [7:0] d);
        if (a == 16'hEFF7) begin
            m_on1m = !d[2];
            m_ram0 = d[3];
            if (!m_on1m) m_page = m_page & 6'h1F;
            else m_lock = 1'b0;
        end else if (a[7:0] == 8'h77) begin
            m_poff = !a[9];
        end else if (!a[15] && !a[1] && !m_lock) begin
            m_rom = d[4];
            if (m_on1m) begin
                m_page = {d[5], d[7:6], d[2:0]};
            end else begin
                m_page = {1'b0, d[7:6], d[2:0]};
                m_lock = d[5];
            end
        end
    endtask

    task automatic push_state();
        st_t s;
        s.page = m_page; s.rom = m_rom; s.ram0 = m_ram0;
        s.on1m = m_on1m; s.poff = m_poff; s.dos = m_dos;
        exp_q.push_back(s);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge fclk);
            #2;
        end
    endtask

    // kind: 0 = I/O write, 1 = I/O read, 2 = M1+IORQ, 3 = memory write
    task automatic bus(input logic [15:0] a, input logic [7:0] d, input int kind, input int nwait);
        za = a;
        zd = d;
        iorq_n = (kind == 3);
        wr_n   = (kind == 1);
        m1_n   = (kind != 2);
        if (kind == 0 && is_atm(a)) atm_q.push_back(a);
        tick(4 * (1 + nwait));
        iorq_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
        tick(8);
        total++;
        if (atm_q.size() != 0) begin
            bad++;
            $display("FAIL atm_missing: addr=%h pending=%0d required=0", a, atm_q.size());
            atm_q.delete();
        end
        if (kind == 0) model_out(a, d);
        push_state();
    endtask

    task automatic dos_pulse(input logic [3:0] on, input logic [3:0] off);
        dos_turn_on = on;
        dos_turn_off = off;
        tick(1);
        dos_turn_on = 4'd0;
        dos_turn_off = 4'd0;
        if (on != 4'd0) m_dos = 1'b1;
        else if (off != 4'd0) m_dos = 1'b0;
        push_state();
    endtask

    // Monitor: state checks, ATM strobe checks and the combinational stall OR.
    initial begin
        st_t s;
        logic [15:0] ea;
        forever begin
            @(negedge fclk);
            total++;
            if (zclk_stall !== (stall_req != 4'd0)) begin
                bad++;
                $display("FAIL zclk_stall: got=%b required=%b (stall_req=%b)",
                         zclk_stall, (stall_req != 4'd0), stall_req);
            end
            if (atmF7_wr === 1'b1) begin
                total++;
                if (atm_q.size() == 0) begin
                    bad++;
                    $display("FAIL atm_spurious: atmF7_wr=1 za=%h required no strobe", za);
                end else begin
                    ea = atm_q.pop_front();
                    if (ea !== za) begin
                        bad++;
                        $display("FAIL atm_addr: got za=%h required=%h", za, ea);
                    end
                end
            end
            if (exp_q.size() != 0) begin
                s = exp_q.pop_front();
                total++;
                if (pent1m_page !== s.page || pent1m_ROM !== s.rom || pent1m_ram0_0 !== s.ram0 ||
                    pent1m_1m_on !== s.on1m || pager_off !== s.poff || dos !== s.dos) begin
                    bad++;
                    $display("FAIL state: got page=%h rom=%b ram0=%b 1m=%b poff=%b dos=%b required page=%h rom=%b ram0=%b 1m=%b poff=%b dos=%b",
                             pent1m_page, pent1m_ROM, pent1m_ram0_0, pent1m_1m_on, pager_off, dos,
                             s.page, s.rom, s.ram0, s.on1m, s.poff, s.dos);
                end
            end
        end
    end

    initial begin
        logic [15:0] addrs [8];
        logic [15:0] a;
        int          k;
        addrs[0] = 16'h7FFD; addrs[1] = 16'hEFF7; addrs[2] = 16'hFFF7; addrs[3] = 16'h7FF7;
        addrs[4] = 16'h37F7; addrs[5] = 16'hBF77; addrs[6] = 16'hFD77; addrs[7] = 16'hFF77;

        rst_n = 1'b0;
        za = 16'hFFFF; zd = 8'h00;
        iorq_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
        dos_turn_on = 4'd0; dos_turn_off = 4'd0; stall_req = 4'd0;
        model_reset();
        tick(4);
        rst_n = 1'b1;
        tick(8);
        push_state();

        // 7FFD with 1 MB off, then lock, then an ignored write
        bus(16'h7FFD, 8'h17, 0, 0);
        bus(16'h7FFD, 8'h20, 0, 0);
        bus(16'h7FFD, 8'h05, 0, 1);

        // 1 MB mode via EFF7
        bus(16'hEFF7, 8'h00, 0, 0);
        bus(16'h7FFD, 8'hE3, 0, 0);
        bus(16'hEFF7, 8'h0C, 0, 0);

        // ATM ports, including a long wait-stated cycle
        bus(16'h7FF7, 8'h55, 0, 3);
        bus(16'hFFF7, 8'hAA, 0, 0);
        bus(16'h37F7, 8'h3C, 0, 2);
        bus(16'hEFF7, 8'h00, 0, 0);
        bus(16'h7FFD, 8'h11, 0, 0);
        bus(16'hBF77, 8'h00, 0, 0);

        // Pager-off port and non-write cycles
        bus(16'hFD77, 8'h00, 0, 0);
        bus(16'hFF77, 8'h00, 0, 0);
        bus(16'hFD77, 8'h00, 1, 0);
        bus(16'hFD77, 8'h00, 2, 0);
        bus(16'hFD77, 8'h00, 3, 0);
        bus(16'hFFF7, 8'h00, 1, 1);

        // DOS flag and stall merge
        dos_pulse(4'b0010, 4'b0000);
        dos_pulse(4'b0000, 4'b1000);
        dos_pulse(4'b0001, 4'b0100);
        stall_req = 4'b0100;
        tick(2);
        stall_req = 4'b0000;
        tick(1);

        // Reset asserted inside an active 7FFD write, released while still active
        za = 16'h7FFD; zd = 8'h17;
        iorq_n = 1'b0; wr_n = 1'b0; m1_n = 1'b1;
        tick(6);
        #1;
        rst_n = 1'b0;
        model_reset();
        tick(2);
        push_state();
        rst_n = 1'b1;
        tick(12);
        push_state();
        iorq_n = 1'b1; wr_n = 1'b1;
        tick(8);
        bus(16'h7FFD, 8'h1A, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, 9);
            if (k < 8) a = addrs[k];
            else a = 16'($urandom);
            bus(a, 8'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                stall_req = 4'($urandom);
                dos_pulse(4'($urandom) & {4{$urandom_range(0, 1) == 1}},
                          4'($urandom));
            end
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge fclk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending state checks=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
